// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: FSM states and byte-lane mask rules.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  function automatic logic mask_legal(input logic [3:0] m);
    return m inside {MASK_B0, MASK_B1, MASK_B2, MASK_B3, MASK_H0, MASK_H1, MASK_W};
  endfunction

  // Exactly one of the two masks may be active, and it must be an aligned lane group.
  function automatic logic op_legal(input logic [3:0] rden, input logic [3:0] wren);
    return (mask_legal(rden) && (wren == 4'b0000)) ||
           (mask_legal(wren) && (rden == 4'b0000));
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus interface between the memory stage (master) and memory (slave).
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Load alignment: picks the addressed lanes out of a bus word and sign/zero-extends them.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [3:0]  rden,
  input  logic        sext,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata;
    result  = rdata;

    // The lowest enabled lane becomes bit 0 of the result.
    if (rden[0])      shifted = rdata;
    else if (rden[1]) shifted = rdata >> 8;
    else if (rden[2]) shifted = rdata >> 16;
    else if (rden[3]) shifted = rdata >> 24;

    if (rden == MASK_W)
      result = shifted;
    else if ((rden == MASK_H0) || (rden == MASK_H1))
      result = {{16{sext & shifted[15]}}, shifted[15:0]};
    else
      result = {{24{sext & shifted[7]}}, shifted[7:0]};
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: turns EX load/store requests into one req/gnt/rvalid bus transaction
// each, stalls upstream meanwhile, and registers the writeback result.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   EX_rd,
  input  logic         EX_rd_vld,
  input  logic [31:0]  EX_x_rd,
  input  logic [31:0]  EX_MEM_addr,
  input  logic [3:0]   EX_MEM_rden,
  input  logic         EX_MEM_rden_SEXT,
  input  logic [3:0]   EX_MEM_wren,
  input  logic [31:0]  EX_MEM_wrdata,
  mem_access_if.master dbus,
  output logic [4:0]   MEM_rd,
  output logic         MEM_rd_vld,
  output logic [31:0]  MEM_x_rd,
  output logic         MEM_stall,
  output logic         MEM_err
);

  localparam int unsigned   CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e        state, state_nxt;
  logic [CW-1:0] tcnt;
  logic          mem_op, expired;
  logic          start, pass, bad, rd_done, abort;
  logic [4:0]    lat_rd;
  logic          lat_rd_vld, lat_sext;
  logic [31:0]   load_data;
  logic          addr_lo_unused;

  // Byte offset is carried by the lane masks, so the low address bits are not needed.
  assign addr_lo_unused = ^EX_MEM_addr[1:0];

  assign mem_op    = (|EX_MEM_rden) | (|EX_MEM_wren);
  assign MEM_stall = (state != ST_IDLE) | mem_op;
  assign expired   = (TIMEOUT != 0) && (tcnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pass      = 1'b0;
    bad       = 1'b0;
    rd_done   = 1'b0;
    abort     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!mem_op)
          pass = 1'b1;
        else if (!op_legal(EX_MEM_rden, EX_MEM_wren))
          bad = 1'b1;
        else begin
          start     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      // A write finishes on gnt; a read grant on the last allowed cycle still times out.
      ST_REQ: begin
        if (dbus.gnt && dbus.we)
          state_nxt = ST_IDLE;
        else if (expired) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (dbus.gnt)
          state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (dbus.rvalid) begin
          rd_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  mem_access_load_align u_align (
    .rdata  (dbus.rdata),
    .rden   (dbus.be),
    .sext   (lat_sext),
    .result (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt       <= '0;
      dbus.req   <= 1'b0;
      dbus.we    <= 1'b0;
      dbus.addr  <= '0;
      dbus.be    <= '0;
      dbus.wdata <= '0;
      lat_rd     <= '0;
      lat_rd_vld <= 1'b0;
      lat_sext   <= 1'b0;
      MEM_rd     <= '0;
      MEM_rd_vld <= 1'b0;
      MEM_x_rd   <= '0;
      MEM_err    <= 1'b0;
    end else begin
      dbus.req   <= (state_nxt == ST_REQ);
      MEM_err    <= bad | abort;
      MEM_rd_vld <= 1'b0;

      if (start) begin
        tcnt       <= '0;
        dbus.we    <= |EX_MEM_wren;
        dbus.addr  <= {EX_MEM_addr[31:2], 2'b00};
        dbus.be    <= EX_MEM_rden | EX_MEM_wren;
        dbus.wdata <= EX_MEM_wrdata;
        lat_rd     <= EX_rd;
        lat_rd_vld <= EX_rd_vld;
        lat_sext   <= EX_MEM_rden_SEXT;
      end else if (state != ST_IDLE) begin
        tcnt <= tcnt + 1'b1;
      end

      if (pass) begin
        MEM_rd     <= EX_rd;
        MEM_x_rd   <= EX_x_rd;
        MEM_rd_vld <= EX_rd_vld;
      end else if (rd_done) begin
        MEM_rd     <= lat_rd;
        MEM_x_rd   <= load_data;
        MEM_rd_vld <= lat_rd_vld;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: one default-timeout DUT plus a TIMEOUT=4 DUT whose bus never grants.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ex_rd;
  logic        ex_rd_vld;
  logic [31:0] ex_x_rd;
  logic [31:0] ex_addr;
  logic [3:0]  ex_rden;
  logic        ex_sext;
  logic [3:0]  ex_wren;
  logic [31:0] ex_wrdata;
  logic [3:0]  t_rden;
  logic [3:0]  t_wren;

  logic [4:0]  mem_rd;
  logic        mem_rd_vld;
  logic [31:0] mem_x_rd;
  logic        mem_stall;
  logic        mem_err;
  logic [4:0]  to_rd;
  logic        to_rd_vld;
  logic [31:0] to_x_rd;
  logic        to_stall;
  logic        to_err;

  int checks   = 0;
  int failures = 0;

  mem_access_if dbus ();
  mem_access_if dbus_to ();

  always #5 clk = ~clk;

  mem_access dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .EX_rd            (ex_rd),
    .EX_rd_vld        (ex_rd_vld),
    .EX_x_rd          (ex_x_rd),
    .EX_MEM_addr      (ex_addr),
    .EX_MEM_rden      (ex_rden),
    .EX_MEM_rden_SEXT (ex_sext),
    .EX_MEM_wren      (ex_wren),
    .EX_MEM_wrdata    (ex_wrdata),
    .dbus             (dbus),
    .MEM_rd           (mem_rd),
    .MEM_rd_vld       (mem_rd_vld),
    .MEM_x_rd         (mem_x_rd),
    .MEM_stall        (mem_stall),
    .MEM_err          (mem_err)
  );

  mem_access #(.TIMEOUT(4)) dut_to (
    .clk              (clk),
    .rst_n            (rst_n),
    .EX_rd            (ex_rd),
    .EX_rd_vld        (ex_rd_vld),
    .EX_x_rd          (ex_x_rd),
    .EX_MEM_addr      (ex_addr),
    .EX_MEM_rden      (t_rden),
    .EX_MEM_rden_SEXT (ex_sext),
    .EX_MEM_wren      (t_wren),
    .EX_MEM_wrdata    (ex_wrdata),
    .dbus             (dbus_to),
    .MEM_rd           (to_rd),
    .MEM_rd_vld       (to_rd_vld),
    .MEM_x_rd         (to_x_rd),
    .MEM_stall        (to_stall),
    .MEM_err          (to_err)
  );

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [4:0] rd, input logic rd_vld, input logic [31:0] x_rd,
                               input logic [31:0] addr, input logic [3:0] rden, input logic sext,
                               input logic [3:0] wren, input logic [31:0] wdata);
    ex_rd     = rd;
    ex_rd_vld = rd_vld;
    ex_x_rd   = x_rd;
    ex_addr   = addr;
    ex_rden   = rden;
    ex_sext   = sext;
    ex_wren   = wren;
    ex_wrdata = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One load with gnt on the gnt_delay-th request cycle; a junk rvalid rides along with gnt.
  task automatic runLoad(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [3:0] rden, input logic sext, input logic [31:0] rdata,
                         input int gnt_delay, input logic [31:0] exp_addr, input logic [31:0] exp_x);
    applyStimulus(rd, 1'b1, 32'h0, addr, rden, sext, 4'b0000, 32'h0);
    #1 checkOutput($sformatf("%s_stall_c0", tag), 32'(mem_stall), 32'd1);
    nextCycle();
    applyStimulus(5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    for (int i = 1; i <= gnt_delay; i++) begin
      #1;
      checkOutput($sformatf("%s_req_%0d", tag, i), 32'(dbus.req), 32'd1);
      checkOutput($sformatf("%s_addr_%0d", tag, i), dbus.addr, exp_addr);
      checkOutput($sformatf("%s_be_%0d", tag, i), 32'(dbus.be), 32'(rden));
      checkOutput($sformatf("%s_we_%0d", tag, i), 32'(dbus.we), 32'd0);
      checkOutput($sformatf("%s_stall_%0d", tag, i), 32'(mem_stall), 32'd1);
      checkOutput($sformatf("%s_vld_%0d", tag, i), 32'(mem_rd_vld), 32'd0);
      if (i == gnt_delay) begin
        dbus.gnt    = 1'b1;
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'hBAD0_BAD0;
      end
      nextCycle();
    end
    dbus.gnt   = 1'b0;
    dbus.rdata = rdata;
    #1;
    checkOutput($sformatf("%s_resp_req", tag), 32'(dbus.req), 32'd0);
    checkOutput($sformatf("%s_resp_stall", tag), 32'(mem_stall), 32'd1);
    checkOutput($sformatf("%s_resp_vld", tag), 32'(mem_rd_vld), 32'd0);
    nextCycle();
    dbus.rvalid = 1'b0;
    dbus.rdata  = 32'h0;
    #1;
    checkOutput($sformatf("%s_wb_vld", tag), 32'(mem_rd_vld), 32'd1);
    checkOutput($sformatf("%s_wb_data", tag), mem_x_rd, exp_x);
    checkOutput($sformatf("%s_wb_rd", tag), 32'(mem_rd), 32'(rd));
    checkOutput($sformatf("%s_wb_stall", tag), 32'(mem_stall), 32'd0);
    nextCycle();
    #1 checkOutput($sformatf("%s_vld_pulse", tag), 32'(mem_rd_vld), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    t_rden = 4'b0000;
    t_wren = 4'b0000;
    dbus.gnt = 1'b0;    dbus.rvalid = 1'b0;    dbus.rdata = 32'h0;
    dbus_to.gnt = 1'b0; dbus_to.rvalid = 1'b0; dbus_to.rdata = 32'h0;

    #12;
    checkOutput("rst_req", 32'(dbus.req), 32'd0);
    checkOutput("rst_vld", 32'(mem_rd_vld), 32'd0);
    checkOutput("rst_xrd", mem_x_rd, 32'h0);
    checkOutput("rst_err", 32'(mem_err), 32'd0);
    checkOutput("rst_stall", 32'(mem_stall), 32'd0);
    checkOutput("rst_to_vld", 32'(to_rd_vld), 32'd0);
    rst_n = 1'b1;

    $display("[TB] non-memory pass-through");
    nextCycle();
    applyStimulus(5'd5, 1'b1, 32'h0000_1234, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    #1 checkOutput("pass_stall_c0", 32'(mem_stall), 32'd0);
    nextCycle();
    applyStimulus(5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    #1;
    checkOutput("pass_rd", 32'(mem_rd), 32'd5);
    checkOutput("pass_xrd", mem_x_rd, 32'h0000_1234);
    checkOutput("pass_vld", 32'(mem_rd_vld), 32'd1);
    checkOutput("pass_stall_c1", 32'(mem_stall), 32'd0);
    nextCycle();

    $display("[TB] byte and half loads");
    runLoad("lb_sext", 5'd7, 32'h0000_0102, 4'b0100, 1'b1, 32'h0080_0000, 1, 32'h0000_0100, 32'hFFFF_FF80);
    runLoad("lb_zext", 5'd8, 32'h0000_0102, 4'b0100, 1'b0, 32'h0080_0000, 1, 32'h0000_0100, 32'h0000_0080);
    runLoad("lh_hi",   5'd3, 32'h0000_0002, 4'b1100, 1'b1, 32'h8001_1234, 3, 32'h0000_0000, 32'hFFFF_8001);

    $display("[TB] store then load");
    applyStimulus(5'd2, 1'b1, 32'h0, 32'h0000_0040, 4'b0000, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    #1 checkOutput("sw_stall_c0", 32'(mem_stall), 32'd1);
    nextCycle();
    applyStimulus(5'd9, 1'b1, 32'h0, 32'h0000_0044, 4'b1111, 1'b0, 4'b0000, 32'h0);
    dbus.gnt = 1'b1;
    #1;
    checkOutput("sw_req", 32'(dbus.req), 32'd1);
    checkOutput("sw_we", 32'(dbus.we), 32'd1);
    checkOutput("sw_be", 32'(dbus.be), 32'hF);
    checkOutput("sw_wdata", dbus.wdata, 32'hDEAD_BEEF);
    checkOutput("sw_addr", dbus.addr, 32'h0000_0040);
    checkOutput("sw_stall_c1", 32'(mem_stall), 32'd1);
    nextCycle();
    dbus.gnt = 1'b0;
    #1;
    checkOutput("sw_done_req", 32'(dbus.req), 32'd0);
    checkOutput("sw_no_vld", 32'(mem_rd_vld), 32'd0);
    checkOutput("sw_stall_c2", 32'(mem_stall), 32'd1);
    nextCycle();
    applyStimulus(5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    dbus.gnt = 1'b1;
    #1;
    checkOutput("lw_req", 32'(dbus.req), 32'd1);
    checkOutput("lw_we", 32'(dbus.we), 32'd0);
    checkOutput("lw_addr", dbus.addr, 32'h0000_0044);
    checkOutput("lw_be", 32'(dbus.be), 32'hF);
    checkOutput("lw_stall_c3", 32'(mem_stall), 32'd1);
    checkOutput("lw_no_vld", 32'(mem_rd_vld), 32'd0);
    nextCycle();
    dbus.gnt    = 1'b0;
    dbus.rvalid = 1'b1;
    dbus.rdata  = 32'hCAFE_F00D;
    #1 checkOutput("lw_stall_c4", 32'(mem_stall), 32'd1);
    nextCycle();
    dbus.rvalid = 1'b0;
    dbus.rdata  = 32'h0;
    #1;
    checkOutput("lw_vld", 32'(mem_rd_vld), 32'd1);
    checkOutput("lw_data", mem_x_rd, 32'hCAFE_F00D);
    checkOutput("lw_rd", 32'(mem_rd), 32'd9);
    checkOutput("lw_stall_c5", 32'(mem_stall), 32'd0);
    nextCycle();

    $display("[TB] illegal mask");
    applyStimulus(5'd3, 1'b1, 32'h99, 32'h0000_0008, 4'b0101, 1'b0, 4'b0000, 32'h0);
    #1 checkOutput("ill_stall", 32'(mem_stall), 32'd1);
    nextCycle();
    applyStimulus(5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    #1;
    checkOutput("ill_req", 32'(dbus.req), 32'd0);
    checkOutput("ill_err", 32'(mem_err), 32'd1);
    checkOutput("ill_vld", 32'(mem_rd_vld), 32'd0);
    nextCycle();
    #1;
    checkOutput("ill_err_pulse", 32'(mem_err), 32'd0);
    checkOutput("ill_req_after", 32'(dbus.req), 32'd0);

    $display("[TB] timeout with TIMEOUT=4");
    applyStimulus(5'd0, 1'b0, 32'h0, 32'h0000_0080, 4'b0000, 1'b0, 4'b0000, 32'h0);
    t_rden = 4'b1111;
    nextCycle();
    t_rden = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checkOutput($sformatf("to_req_%0d", i), 32'(dbus_to.req), 32'd1);
      checkOutput($sformatf("to_err_%0d", i), 32'(to_err), 32'd0);
      checkOutput($sformatf("to_stall_%0d", i), 32'(to_stall), 32'd1);
      nextCycle();
    end
    #1;
    checkOutput("to_req_drop", 32'(dbus_to.req), 32'd0);
    checkOutput("to_err", 32'(to_err), 32'd1);
    checkOutput("to_vld", 32'(to_rd_vld), 32'd0);
    checkOutput("to_addr", dbus_to.addr, 32'h0000_0080);
    checkOutput("to_be", 32'(dbus_to.be), 32'hF);
    checkOutput("to_we", 32'(dbus_to.we), 32'd0);
    checkOutput("to_wdata", dbus_to.wdata, 32'h0);
    checkOutput("to_xrd", to_x_rd, 32'h0);
    checkOutput("to_rd", 32'(to_rd), 32'd0);
    nextCycle();
    dbus_to.gnt    = 1'b1;
    dbus_to.rvalid = 1'b1;
    dbus_to.rdata  = 32'h1234_5678;
    #1 checkOutput("to_err_pulse", 32'(to_err), 32'd0);
    nextCycle();
    dbus_to.gnt    = 1'b0;
    dbus_to.rvalid = 1'b0;
    #1;
    checkOutput("to_late_vld", 32'(to_rd_vld), 32'd0);
    checkOutput("to_late_req", 32'(dbus_to.req), 32'd0);
    checkOutput("to_late_err", 32'(to_err), 32'd0);

    $display("[TB] reset during RESP");
    applyStimulus(5'd6, 1'b1, 32'h0000_ABCD, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    nextCycle();
    applyStimulus(5'd4, 1'b1, 32'h0, 32'h0000_0010, 4'b0001, 1'b0, 4'b0000, 32'h0);
    #1;
    checkOutput("rr_pass_xrd", mem_x_rd, 32'h0000_ABCD);
    checkOutput("rr_pass_rd", 32'(mem_rd), 32'd6);
    nextCycle();
    applyStimulus(5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 4'b0000, 32'h0);
    dbus.gnt = 1'b1;
    #1;
    checkOutput("rr_req", 32'(dbus.req), 32'd1);
    checkOutput("rr_hold_xrd", mem_x_rd, 32'h0000_ABCD);
    nextCycle();
    dbus.gnt = 1'b0;
    #1 checkOutput("rr_resp_stall", 32'(mem_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rr_rst_req", 32'(dbus.req), 32'd0);
    checkOutput("rr_rst_addr", dbus.addr, 32'h0);
    checkOutput("rr_rst_be", 32'(dbus.be), 32'd0);
    checkOutput("rr_rst_xrd", mem_x_rd, 32'h0);
    checkOutput("rr_rst_rd", 32'(mem_rd), 32'd0);
    checkOutput("rr_rst_vld", 32'(mem_rd_vld), 32'd0);
    checkOutput("rr_rst_err", 32'(mem_err), 32'd0);
    checkOutput("rr_rst_stall", 32'(mem_stall), 32'd0);
    #2 rst_n = 1'b1;
    nextCycle();
    dbus.rvalid = 1'b1;
    dbus.rdata  = 32'h0000_0011;
    nextCycle();
    dbus.rvalid = 1'b0;
    #1;
    checkOutput("rr_late_vld", 32'(mem_rd_vld), 32'd0);
    checkOutput("rr_late_err", 32'(mem_err), 32'd0);
    checkOutput("rr_late_req", 32'(dbus.req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
